os_drain_serializer: RTL and testbench



---
 rtl/os_drain_pkg.sv | 15 +
 rtl/os_drain_serializer_if.sv | 9 +
 rtl/os_drain_lane.sv | 30 +++
 rtl/os_drain_serializer.sv | 65 ++++++
 tb/tb_os_drain_serializer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/os_drain_pkg.sv
// os_drain_pkg: shared state encoding, element type and size helpers for the OS drain serializer
package os_drain_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  localparam int PSUM_BW = 16;
  typedef logic signed [PSUM_BW-1:0] psum_t;
  function automatic int num_elem(input int r, input int c);
    return r * c;
  endfunction
  function automatic int beats(input int r, input int c, input int l);
    return r * c / l;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/os_drain_serializer_if.sv
// os_drain_serializer_if: valid/ready beat stream carrying payload and beat index
interface os_drain_serializer_if #(parameter int dw = 16, parameter int iw = 6);
  logic [dw-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [iw-1:0] out_idx;
  modport master(output out_data, out_valid, out_idx, input out_ready);
  modport slave(input out_data, out_valid, out_idx, output out_ready);
endinterface

// File: rtl/os_drain_lane.sv
// os_drain_lane: picks one lane's element for a beat and applies ReLU; OS_DRAIN_TRANSPOSE_EN selects column-major order
module os_drain_lane import os_drain_pkg::*; #(
  parameter int psum_bw = 16,
  parameter int col = 8,
  parameter int row = 8,
  parameter int lanes = 1,
  parameter int lane = 0,
  parameter int iw = 6
) (
  input  logic [psum_bw*col*row-1:0] src,
  input  logic [iw-1:0] idx,
  input  logic relu,
  output logic [psum_bw-1:0] y
);
  localparam int NE = num_elem(row, col);
  localparam int EW = idx_w(NE);
  logic [psum_bw-1:0] el [NE];
  logic [EW-1:0] e;
  for (genvar i = 0; i < NE; i++) begin : g_el
    assign el[i] = src[i*psum_bw +: psum_bw];
  end
  always_comb begin
`ifdef OS_DRAIN_TRANSPOSE_EN
    e = EW'(((int'(idx) * lanes + lane) % row) * col + (int'(idx) * lanes + lane) / row);
`else
    e = EW'(int'(idx) * lanes + lane);
`endif
    y = relu && el[e][psum_bw-1] ? '0 : el[e];
  end
endmodule

// File: rtl/os_drain_serializer.sv
// os_drain_serializer: snapshots an OS tile on start and streams it lanes-wide; OS_DRAIN_TRANSPOSE_EN gives column-major order
module os_drain_serializer import os_drain_pkg::*; #(
  parameter int psum_bw = 16,
  parameter int col = 8,
  parameter int row = 8,
  parameter int lanes = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic relu,
  input  logic [psum_bw*col*row-1:0] os_out_array,
  output logic busy,
  output logic done,
  os_drain_serializer_if.master o
);
  localparam int NE = num_elem(row, col);
  localparam int BEATS = beats(row, col, lanes);
  localparam int IW = idx_w(BEATS);
  if (NE % lanes != 0) begin : g_chk
    $error("lanes must divide row*col");
  end
  state_t st, nx;
  logic [NE*psum_bw-1:0] snap, src;
  logic relu_q, rs, fire, last, load;
  logic [IW-1:0] nidx;
  logic [psum_bw*lanes-1:0] nd;
  assign o.out_valid = st == DRAIN;
  assign busy = st != IDLE;
  assign done = st == DONE;
  always_comb begin
    fire = o.out_valid & o.out_ready;
    last = o.out_idx == IW'(BEATS - 1);
    nx = st == IDLE ? (start ? DRAIN : IDLE) : st == DRAIN ? (fire && last ? DONE : DRAIN) : IDLE;
    load = (st == IDLE && start) || (fire && !last);
    nidx = st == IDLE ? '0 : o.out_idx + IW'(1);
    // at the capture edge the lanes look at the live array so beat 0 is registered with the snapshot
    src = st == IDLE ? os_out_array : snap;
    rs = st == IDLE ? relu : relu_q;
  end
  for (genvar k = 0; k < lanes; k++) begin : g_lane
    os_drain_lane #(.psum_bw(psum_bw), .col(col), .row(row), .lanes(lanes), .lane(k), .iw(IW)) u_lane (
      .src(src), .idx(nidx), .relu(rs), .y(nd[k*psum_bw +: psum_bw])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      snap <= '0;
      relu_q <= 1'b0;
      o.out_data <= '0;
      o.out_idx <= '0;
    end else begin
      st <= nx;
      if (st == IDLE && start) begin
        snap <= os_out_array;
        relu_q <= relu;
      end
      if (load) begin
        o.out_data <= nd;
        o.out_idx <= nidx;
      end
    end
  end
endmodule

// File: tb/tb_os_drain_serializer.sv
// tb_os_drain_serializer: directed bench with a queue-based model for a 1-lane and a 4-lane serializer
module tb_os_drain_serializer;
  import os_drain_pkg::*;
  logic clk = 0, reset = 1, relu = 0, start1 = 0, start4 = 0, bp_en = 0, rdy1 = 1, rdy4 = 1;
  logic [1023:0] arr;
  logic busy1, done1, busy4, done4;
  int tests = 0, fails = 0, edges = 0, pc = 0;
  int vals[64];
  logic [15:0] q1[$];
  logic [63:0] q4[$];
  int ei1 = 0, ei4 = 0, dn1 = 0, dn4 = 0, de1 = 0, de4 = 0, st_edge = 0;
  bit ed1 = 0, ed4 = 0, st1 = 0, st4 = 0;
  logic [15:0] h1d;
  logic [63:0] h4d;
  logic [5:0] h1i;
  logic [3:0] h4i;

  os_drain_serializer_if #(.dw(16), .iw(6)) s1();
  os_drain_serializer_if #(.dw(64), .iw(4)) s4();
  assign s1.out_ready = rdy1;
  assign s4.out_ready = rdy4;

  os_drain_serializer #(.psum_bw(16), .col(8), .row(8), .lanes(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .relu(relu), .os_out_array(arr),
    .busy(busy1), .done(done1), .o(s1));
  os_drain_serializer #(.psum_bw(16), .col(8), .row(8), .lanes(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .relu(relu), .os_out_array(arr),
    .busy(busy4), .done(done4), .o(s4));

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  // ready pattern 1,0,0,1 for the 4-lane drain while backpressure is enabled
  always @(posedge clk) begin
    #1;
    rdy4 = bp_en ? (pc % 4 == 0 || pc % 4 == 3) : 1'b1;
    pc = bp_en ? pc + 1 : 0;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  function automatic int pos2e(input int p);
`ifdef OS_DRAIN_TRANSPOSE_EN
    return (p % 8) * 8 + p / 8;
`else
    return p;
`endif
  endfunction

  function automatic logic [15:0] mval(input int p, input bit r);
    int v;
    v = vals[pos2e(p)];
    if (r && v < 0) v = 0;
    return 16'(v);
  endfunction

  task automatic load_ramp();
    for (int e = 0; e < 64; e++) begin
      vals[e] = e - 32;
      arr[e*16 +: 16] = 16'(vals[e]);
    end
  endtask

  task automatic launch(input bit wide, input bit r);
    logic [63:0] w;
    @(posedge clk);
    #1;
    relu = r;
    if (wide) begin
      q4.delete();
      for (int b = 0; b < 16; b++) begin
        for (int k = 0; k < 4; k++) w[k*16 +: 16] = mval(b * 4 + k, r);
        q4.push_back(w);
      end
      ei4 = 0; ed4 = 1; start4 = 1;
    end else begin
      q1.delete();
      for (int b = 0; b < 64; b++) q1.push_back(mval(b, r));
      ei1 = 0; ed1 = 1; start1 = 1;
    end
    @(posedge clk);
    #1;
    st_edge = edges;
    start1 = 0;
    start4 = 0;
  endtask

  task automatic wait_done(input bit wide, input int lim);
    int n0, i;
    n0 = wide ? dn4 : dn1;
    i = 0;
    while ((wide ? dn4 : dn1) == n0 && i < lim) begin
      @(posedge clk);
      i++;
    end
    chk(wide ? "u4_done_in_time" : "u1_done_in_time", i < lim, 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (st1) begin
        chk("u1_hold_valid", s1.out_valid, 1);
        chk("u1_hold_data", s1.out_data, h1d);
        chk("u1_hold_idx", s1.out_idx, h1i);
      end
      st1 = s1.out_valid && !s1.out_ready;
      h1d = s1.out_data;
      h1i = s1.out_idx;
      if (s1.out_valid && s1.out_ready) begin
        chk("u1_beat_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          chk("u1_data", s1.out_data, q1.pop_front());
          chk("u1_idx", s1.out_idx, ei1);
          ei1++;
        end
      end
      if (done1) begin
        chk("u1_done_expected", {ed1, q1.size() == 0}, 2'b11);
        ed1 = 0; dn1++; de1 = edges;
      end
      if (st4) begin
        chk("u4_hold_valid", s4.out_valid, 1);
        chk("u4_hold_data", s4.out_data, h4d);
        chk("u4_hold_idx", s4.out_idx, h4i);
      end
      st4 = s4.out_valid && !s4.out_ready;
      h4d = s4.out_data;
      h4i = s4.out_idx;
      if (s4.out_valid && s4.out_ready) begin
        chk("u4_beat_expected", q4.size() != 0, 1);
        if (q4.size() != 0) begin
          chk("u4_data", s4.out_data, q4.pop_front());
          chk("u4_idx", s4.out_idx, ei4);
          ei4++;
        end
      end
      if (done4) begin
        chk("u4_done_expected", {ed4, q4.size() == 0}, 2'b11);
        ed4 = 0; dn4++; de4 = edges;
      end
    end else begin
      st1 = 0;
      st4 = 0;
    end
  end

  initial begin
    int n, i;
    load_ramp();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid1", s1.out_valid, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_idx1", s1.out_idx, 0);
    chk("rst_data1", s1.out_data, 0);
    chk("rst_valid4", s4.out_valid, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_data4", s4.out_data, 0);
    reset = 0;
    // basic row-major drain, ready held high
    launch(0, 0);
    @(negedge clk);
    chk("u1_first_beat", s1.out_data, 16'hFFE0);
    chk("u1_busy", busy1, 1);
    wait_done(0, 200);
    chk("u1_latency", de1 - st_edge + 1, 65);
    chk("u1_beats", ei1, 64);
    @(negedge clk);
    chk("u1_idle_after", busy1, 0);
    // ReLU latched at start; toggling it mid-drain must not matter
    launch(0, 1);
    @(negedge clk);
    chk("u1_relu_first", s1.out_data, 0);
    repeat (5) @(posedge clk);
    #1 relu = 0;
    wait_done(0, 200);
    chk("u1_relu_beats", ei1, 64);
    // 4 lanes under backpressure
    bp_en = 1;
    launch(1, 0);
    @(negedge clk);
`ifdef OS_DRAIN_TRANSPOSE_EN
    chk("u4_first_beat", s4.out_data, 64'hFFF8FFF0FFE8FFE0);
`else
    chk("u4_first_beat", s4.out_data, 64'hFFE3FFE2FFE1FFE0);
`endif
    wait_done(1, 300);
    chk("u4_beats", ei4, 16);
    bp_en = 0;
    // snapshot isolation and start while busy
    n = dn1;
    launch(0, 0);
    arr = {64{16'h7FFF}};
    repeat (3) @(posedge clk);
    #1;
    start1 = 1; relu = 1;
    @(posedge clk);
    #1;
    start1 = 0; relu = 0;
    wait_done(0, 200);
    repeat (10) @(posedge clk);
    chk("u1_single_done", dn1 - n, 1);
    chk("u1_iso_beats", ei1, 64);
    load_ramp();
    // reset in the middle of a drain
    launch(0, 0);
    i = 0;
    while (s1.out_idx != 10 && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("u1_reached_beat10", s1.out_idx, 10);
    reset = 1;
    n = dn1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", s1.out_valid, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_idx", s1.out_idx, 0);
    chk("mid_rst_done", done1, 0);
    reset = 0;
    q1.delete();
    ed1 = 0;
    repeat (3) @(posedge clk);
    chk("mid_rst_no_done", dn1 - n, 0);
    launch(0, 0);
    @(negedge clk);
    chk("restart_idx0", s1.out_idx, 0);
    wait_done(0, 200);
    chk("restart_beats", ei1, 64);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
